// File: rtl/decode_stage_controller_pkg.sv
// decoder_stage_pkg: stage encodings and PU-array sizing shared across the decoder
package decoder_stage_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_GROW     = 3'd2,
    ST_MERGE    = 3'd3,
    ST_BOUNDARY = 3'd4,
    ST_RESULT   = 3'd5
  } stage_e;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  function automatic int pu_count(input int x, input int z);
    return x * z * max_int(x, z);
  endfunction
  localparam int DEFAULT_DISTANCE_X = 4;
  localparam int DEFAULT_DISTANCE_Z = 12;
  localparam int DEFAULT_PU_COUNT = pu_count(DEFAULT_DISTANCE_X, DEFAULT_DISTANCE_Z);
endpackage

// File: rtl/decode_stage_controller_settle.sv
// settle_detector: flags convergence on the Nth consecutive cycle with no busy PU
module settle_detector #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic any_busy,
  output logic converged
);
  localparam int W = $clog2(SETTLE_CYCLES + 1);
  logic [W-1:0] idle_count;
  // the current idle cycle completes the run, so compare against N-1
  assign converged = !any_busy && idle_count == W'(SETTLE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset || clear || any_busy) idle_count <= '0;
    else if (idle_count != W'(SETTLE_CYCLES - 1)) idle_count <= idle_count + 1'b1;
  end
endmodule

// File: rtl/decode_stage_controller.sv
// decode_stage_controller: sequences load/grow/merge/boundary for one union-find decoding round
module decode_stage_controller
  import decoder_stage_pkg::*;
#(
  parameter int CODE_DISTANCE_X = DEFAULT_DISTANCE_X,
  parameter int CODE_DISTANCE_Z = DEFAULT_DISTANCE_Z,
  parameter int PU_COUNT = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  parameter int MAX_ITERATIONS = 16,
  parameter int ITER_WIDTH = $clog2(MAX_ITERATIONS + 1),
  parameter int MERGE_SETTLE_CYCLES = 3,
  parameter int MERGE_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PU_COUNT-1:0]   pu_busy,
  input  logic                  any_odd_cluster,
  output logic                  card_go,
  input  logic                  card_done,
  input  logic                  card_final,
  output logic [2:0]            stage,
  output logic [ITER_WIDTH-1:0] iteration,
  output logic                  result_valid,
  output logic                  result_parity,
  output logic                  result_failed,
  output logic                  busy
);
  localparam int TW = $clog2(MERGE_TIMEOUT + 1);
  stage_e st;
  logic [TW-1:0] merge_timer;
  logic converged, timed_out, last_iter;
  assign stage = st;
  assign busy = st != ST_IDLE;
  assign timed_out = merge_timer == TW'(MERGE_TIMEOUT - 1);
  assign last_iter = iteration == ITER_WIDTH'(MAX_ITERATIONS - 1);
  settle_detector #(.SETTLE_CYCLES(MERGE_SETTLE_CYCLES)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .clear    (st != ST_MERGE),
    .any_busy (|pu_busy),
    .converged(converged)
  );
  // card_go doubles as the first-BOUNDARY-cycle marker so card_done is ignored there
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_IDLE;
      iteration     <= '0;
      card_go       <= 1'b0;
      result_valid  <= 1'b0;
      result_parity <= 1'b0;
      result_failed <= 1'b0;
      merge_timer   <= '0;
    end else begin
      card_go      <= 1'b0;
      result_valid <= st == ST_RESULT;
      case (st)
        ST_IDLE: if (start) begin
          st            <= ST_LOAD;
          iteration     <= '0;
          result_parity <= 1'b0;
          result_failed <= 1'b0;
        end
        ST_LOAD: st <= ST_GROW;
        ST_GROW: begin
          merge_timer <= '0;
          st          <= ST_MERGE;
        end
        ST_MERGE: begin
          merge_timer <= merge_timer + 1'b1;
          if (converged && !any_odd_cluster) begin
            st      <= ST_BOUNDARY;
            card_go <= 1'b1;
          end else if (converged) begin
            iteration     <= (iteration == ITER_WIDTH'(MAX_ITERATIONS)) ? iteration : iteration + 1'b1;
            result_failed <= last_iter;
            st            <= last_iter ? ST_RESULT : ST_GROW;
          end else if (timed_out) begin
            result_failed <= 1'b1;
            st            <= ST_RESULT;
          end
        end
        ST_BOUNDARY: if (card_done && !card_go) begin
          result_parity <= card_final;
          st            <= ST_RESULT;
        end
        ST_RESULT: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule
